mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the 5-stage RV32I core, directly downstream of the ALU via the exe/mem pipeline register. It passes ALU results through to writeback and runs loads and stores on the data bus with a req/ack handshake. It stalls the pipeline while a transaction is outstanding. Its registered outputs form the mem/wb boundary.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- reg_waddr_i  in  5  destination register from exe/mem
- reg_we_i  in  1  register write enable from exe/mem
- reg_wdata_i  in  32  ALU result; effective address for load/store
- memOp_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- store_data_i  in  32  rs2 value for stores
- stall_req_o  out  1  combinational; upstream holds all inputs while 1
- reg_waddr_o  out  5  to mem/wb
- reg_we_o  out  1  to mem/wb
- reg_wdata_o  out  32  to mem/wb
- dbus_req_o  out  1  transaction request, registered
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_be_o  out  4  byte enables
- dbus_rdata_i  in  32  read data, valid with ack
- dbus_ack_i  in  1  one-cycle completion strobe
- misalign_o  out  1  misaligned-access pulse (see Configuration)

## Operation
- FSM states: IDLE, BUSY.
- IDLE, memOp NONE:
  - Next edge registers reg_waddr/we/wdata to outputs.
  - stall_req_o = 0.
- IDLE, load/store:
  - stall_req_o = 1.
  - Next edge latches address, op, store data and waddr/we.
  - Asserts dbus_req_o with address/we/be/wdata, enters BUSY.
  - Same edge writes a bubble to the outputs (reg_we_o=0, waddr=0, wdata=0).
- BUSY:
  - dbus_req_o and all bus outputs are held stable.
  - stall_req_o = ~dbus_ack_i.
  - Outputs stay a bubble while no ack.
- BUSY, ack:
  - Edge drops dbus_req_o and returns to IDLE.
  - Load: reg_we_o = latched reg_we_i, waddr = latched waddr, wdata = formatted rdata.
  - Store: reg_we_o = 0.
  - Upstream advances on the same edge.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads drive be as their access size.
- Store data:
  - SB replicates byte[7:0] ×4.
  - SH replicates half[15:0] ×2.
  - SW passes through.
- Load formatting:
  - Select the byte/half lane by addr[1:0]/addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- dbus_ack_i is ignored in IDLE.
- dbus_rdata_i is sampled only on the ack edge.
- Reset (any state, including mid-transaction):
  - Returns to IDLE immediately.
  - All outputs 0 (dbus_req_o=0, reg_we_o=0, misalign_o=0).
  - The bus slave must tolerate req dropping without ack.

## Timing
- Non-memory op: 1-cycle latency, full throughput.
- Memory op:
  - Cycle 0: op presented, stall=1.
  - Cycle 1: req=1.
  - Earliest ack is in cycle 1.
  - Result appears on the outputs at the edge ending the ack cycle.
  - Minimum 2 cycles per memory op; +1 per extra wait cycle.
- stall_req_o is purely combinational from state, memOp_i and dbus_ack_i. No dependency on dbus_rdata_i.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
  - No bus transaction; stays in IDLE with stall_req_o=0.
  - Next edge: misalign_o=1 for one cycle, reg_we_o=0, reg_wdata_o=faulting address.
- MISALIGN_TRAP_EN undefined:
  - misalign_o tied 0.
  - Misaligned halfword/word accesses proceed with the offending low address bits forced to 0.

## Test plan
- ADD result passthrough: waddr=5, we=1, wdata=32'h1234, memOp=0 -> next cycle outputs equal inputs; stall_req_o never 1.
- LB at 0x1003, rdata=32'h80FF_0000, ack in req cycle:
  - reg_wdata_o=32'hFFFF_FF80 two edges after presentation.
  - dbus_be_o=4'b1000, dbus_addr_o=0x1000.
  - stall_req_o high exactly 1 cycle.
- SH at 0x2002, store_data=32'hDEAD_BEEF, ack after 3 wait cycles:
  - be=4'b1100, wdata=32'hBEEF_BEEF, we=1.
  - stall held until the ack cycle; reg_we_o=0 throughout.
- LHU at 0x0, rdata=32'h0000_8001 -> reg_wdata_o=32'h0000_8001. LH at 0x2 with rdata=32'h8001_0000 -> reg_wdata_o=32'hFFFF_8001.
- Assert rst_i while BUSY:
  - dbus_req_o falls asynchronously; all outputs 0.
  - After release, an ack in IDLE is ignored and the next NONE op passes through.
- LW at 0x1001:
  - With MISALIGN_TRAP_EN: no req, misalign_o pulse, reg_wdata_o=0x1001.
  - Without MISALIGN_TRAP_EN: dbus_addr_o=0x1000, normal load.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory-access stage of the RV32I pipeline (exe/mem -> mem/wb).
// Passes ALU results through to writeback and runs loads and stores on the data bus
// with a req/ack handshake. While a transaction is outstanding it stalls upstream.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   reg_waddr_i/we_i/wdata_i   destination, write enable, ALU result / effective address
//   memOp_i, store_data_i      memory operation code, rs2 value for stores
//   stall_req_o                combinational stall to upstream
//   reg_waddr_o/we_o/wdata_o   registered mem/wb outputs
//   dbus_*                     registered data-bus request, ack/rdata inputs
//   misalign_o                 one-cycle misaligned-access pulse
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses
// instead of forcing the offending low address bits to zero.
module mem_access (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic        reg_we_i,
   input  logic [31:0] reg_wdata_i,
   input  logic [3:0]  memOp_i,
   input  logic [31:0] store_data_i,
   output logic        stall_req_o,
   output logic [4:0]  reg_waddr_o,
   output logic        reg_we_o,
   output logic [31:0] reg_wdata_o,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   output logic [3:0]  dbus_be_o,
   input  logic [31:0] dbus_rdata_i,
   input  logic        dbus_ack_i,
   output logic        misalign_o
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   localparam logic [3:0] OpLb  = 4'd1;
   localparam logic [3:0] OpLh  = 4'd2;
   localparam logic [3:0] OpLw  = 4'd3;
   localparam logic [3:0] OpLbu = 4'd4;
   localparam logic [3:0] OpLhu = 4'd5;
   localparam logic [3:0] OpSb  = 4'd6;
   localparam logic [3:0] OpSh  = 4'd7;
   localparam logic [3:0] OpSw  = 4'd8;

   state_e      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [1:0]  lane_q, lane_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        we_q, we_d;
   logic        req_d, bus_we_d, we_o_d, misalign_d;
   logic [31:0] addr_d, bus_wdata_d, wdata_o_d;
   logic [3:0]  be_d;
   logic [4:0]  waddr_o_d;

   logic        is_load, is_store, is_mem, mis_addr, misalign;
   logic [1:0]  size;  // 0 byte, 1 half, 2 word
   logic [31:0] eff_addr, load_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Decode of the incoming op
   always_comb begin
      is_load  = (memOp_i >= OpLb) && (memOp_i <= OpLhu);
      is_store = (memOp_i >= OpSb) && (memOp_i <= OpSw);
      is_mem   = is_load || is_store;
      unique case (memOp_i)
         OpLb, OpLbu, OpSb: size = 2'd0;
         OpLh, OpLhu, OpSh: size = 2'd1;
         default:           size = 2'd2;
      endcase
      mis_addr = is_mem && (((size == 2'd1) && reg_wdata_i[0]) ||
                            ((size == 2'd2) && (reg_wdata_i[1:0] != 2'b00)));
`ifdef MISALIGN_TRAP_EN
      misalign = mis_addr;
`else
      misalign = 1'b0;
`endif
      // Forcing is harmless when trapping: a misaligned access never reaches the bus
      eff_addr = reg_wdata_i;
      if (size == 2'd1) eff_addr[0] = 1'b0;
      if (size == 2'd2) eff_addr[1:0] = 2'b00;
   end

   // Load formatting from the latched lane and op
   always_comb begin
      unique case (lane_q)
         2'd0:    ld_byte = dbus_rdata_i[7:0];
         2'd1:    ld_byte = dbus_rdata_i[15:8];
         2'd2:    ld_byte = dbus_rdata_i[23:16];
         default: ld_byte = dbus_rdata_i[31:24];
      endcase
      ld_half = lane_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
      unique case (op_q)
         OpLb:    load_data = {{24{ld_byte[7]}}, ld_byte};
         OpLbu:   load_data = {24'h0, ld_byte};
         OpLh:    load_data = {{16{ld_half[15]}}, ld_half};
         OpLhu:   load_data = {16'h0, ld_half};
         default: load_data = dbus_rdata_i;
      endcase
   end

   // Next state and outputs
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lane_d      = lane_q;
      waddr_d     = waddr_q;
      we_d        = we_q;
      req_d       = dbus_req_o;
      bus_we_d    = dbus_we_o;
      addr_d      = dbus_addr_o;
      bus_wdata_d = dbus_wdata_o;
      be_d        = dbus_be_o;
      waddr_o_d   = 5'd0;
      we_o_d      = 1'b0;
      wdata_o_d   = 32'd0;
      misalign_d  = 1'b0;
      stall_req_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (misalign) begin
               misalign_d = 1'b1;
               wdata_o_d  = reg_wdata_i;
            end else if (is_mem) begin
               stall_req_o = 1'b1;
               state_d     = StBusy;
               op_d        = memOp_i;
               lane_d      = eff_addr[1:0];
               waddr_d     = reg_waddr_i;
               we_d        = reg_we_i;
               req_d       = 1'b1;
               bus_we_d    = is_store;
               addr_d      = {eff_addr[31:2], 2'b00};
               unique case (size)
                  2'd0: begin
                     be_d        = 4'b0001 << eff_addr[1:0];
                     bus_wdata_d = {4{store_data_i[7:0]}};
                  end
                  2'd1: begin
                     be_d        = 4'b0011 << {eff_addr[1], 1'b0};
                     bus_wdata_d = {2{store_data_i[15:0]}};
                  end
                  default: begin
                     be_d        = 4'b1111;
                     bus_wdata_d = store_data_i;
                  end
               endcase
            end else begin
               waddr_o_d = reg_waddr_i;
               we_o_d    = reg_we_i;
               wdata_o_d = reg_wdata_i;
            end
         end
         StBusy: begin
            stall_req_o = ~dbus_ack_i;
            if (dbus_ack_i) begin
               state_d = StIdle;
               req_d   = 1'b0;
               if (op_q <= OpLhu) begin
                  waddr_o_d = waddr_q;
                  we_o_d    = we_q;
                  wdata_o_d = load_data;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         op_q         <= 4'd0;
         lane_q       <= 2'd0;
         waddr_q      <= 5'd0;
         we_q         <= 1'b0;
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= 32'd0;
         dbus_wdata_o <= 32'd0;
         dbus_be_o    <= 4'd0;
         reg_waddr_o  <= 5'd0;
         reg_we_o     <= 1'b0;
         reg_wdata_o  <= 32'd0;
         misalign_o   <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         lane_q       <= lane_d;
         waddr_q      <= waddr_d;
         we_q         <= we_d;
         dbus_req_o   <= req_d;
         dbus_we_o    <= bus_we_d;
         dbus_addr_o  <= addr_d;
         dbus_wdata_o <= bus_wdata_d;
         dbus_be_o    <= be_d;
         reg_waddr_o  <= waddr_o_d;
         reg_we_o     <= we_o_d;
         reg_wdata_o  <= wdata_o_d;
         misalign_o   <= misalign_d;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: scenario tasks with a writeback scoreboard queue.
module tb_mem_access;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  reg_waddr_i;
   logic        reg_we_i;
   logic [31:0] reg_wdata_i;
   logic [3:0]  memOp_i;
   logic [31:0] store_data_i;
   logic        stall_req_o;
   logic [4:0]  reg_waddr_o;
   logic        reg_we_o;
   logic [31:0] reg_wdata_o;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_rdata_i;
   logic        dbus_ack_i;
   logic        misalign_o;

   mem_access dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
      .memOp_i(memOp_i), .store_data_i(store_data_i), .stall_req_o(stall_req_o),
      .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_rdata_i(dbus_rdata_i),
      .dbus_ack_i(dbus_ack_i), .misalign_o(misalign_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [4:0]  wa;
      logic        we;
      logic [31:0] wd;
   } wb_t;

   wb_t sb_q[$];
   int  errors = 0;
   int  checks = 0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference load formatting
   function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
      logic [31:0] b, h;
      b = rdata >> (8 * addr[1:0]);
      h = rdata >> (16 * addr[1]);
      case (op)
         4'd1:    return {{24{b[7]}}, b[7:0]};
         4'd2:    return {{16{h[15]}}, h[15:0]};
         4'd4:    return {24'h0, b[7:0]};
         4'd5:    return {16'h0, h[15:0]};
         default: return rdata;
      endcase
   endfunction

   // Drives one op (called right after a posedge) and runs it to completion.
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wa, input logic we, input int waits,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_bwd, input logic [31:0] exp_wd);
      wb_t         exp, got;
      logic        is_mem, is_store;
      logic [31:0] exp_addr;
      is_mem   = (op >= 4'd1) && (op <= 4'd8);
      is_store = (op >= 4'd6) && (op <= 4'd8);
      exp_addr = {addr[31:2], 2'b00};
      memOp_i = op; reg_wdata_i = addr; store_data_i = sdata; reg_waddr_i = wa; reg_we_i = we;
      if (!is_mem)       exp = '{wa: wa, we: we, wd: addr};
      else if (is_store) exp = '{wa: 5'd0, we: 1'b0, wd: 32'd0};
      else               exp = '{wa: wa, we: we, wd: exp_wd};
      sb_q.push_back(exp);
      @(negedge clk_i);
      checks++;
      if (stall_req_o !== is_mem) begin
         errors++; $display("FAIL stall_c0 op=%0d: got %b expected %b", op, stall_req_o, is_mem);
      end
      if (is_mem) begin
         @(posedge clk_i); #1;
         checks++;
         if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, reg_we_o}
             !== {1'b1, is_store, exp_addr, exp_be, 1'b0}) begin
            errors++;
            $display("FAIL bus_req op=%0d: got req=%b we=%b addr=%h be=%b rwe=%b expected 1 %b %h %b 0",
                     op, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, reg_we_o,
                     is_store, exp_addr, exp_be);
         end
         if (is_store) begin
            checks++;
            if (dbus_wdata_o !== exp_bwd) begin
               errors++; $display("FAIL bus_wdata: got %h expected %h", dbus_wdata_o, exp_bwd);
            end
         end
         for (int i = 0; i < waits; i++) begin
            @(negedge clk_i);
            checks++;
            if (stall_req_o !== 1'b1) begin
               errors++; $display("FAIL stall_wait%0d: got %b expected 1", i, stall_req_o);
            end
            @(posedge clk_i); #1;
            checks++;
            if ({dbus_req_o, dbus_addr_o, dbus_be_o, reg_we_o} !== {1'b1, exp_addr, exp_be, 1'b0})
            begin
               errors++;
               $display("FAIL hold_wait%0d: got req=%b addr=%h be=%b rwe=%b expected 1 %h %b 0",
                        i, dbus_req_o, dbus_addr_o, dbus_be_o, reg_we_o, exp_addr, exp_be);
            end
         end
         dbus_ack_i = 1'b1; dbus_rdata_i = rdata;
         @(negedge clk_i);
         checks++;
         if (stall_req_o !== 1'b0) begin
            errors++; $display("FAIL stall_ack: got %b expected 0", stall_req_o);
         end
      end
      @(posedge clk_i); #1;
      dbus_ack_i = 1'b0; dbus_rdata_i = 32'h5A5A_A5A5;
      if (is_mem) begin
         checks++;
         if (dbus_req_o !== 1'b0) begin
            errors++; $display("FAIL req_drop: got %b expected 0", dbus_req_o);
         end
      end
      got = '{wa: reg_waddr_o, we: reg_we_o, wd: reg_wdata_o};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL writeback op=%0d: got wa=%0d we=%b wd=%h expected wa=%0d we=%b wd=%h",
                  op, got.wa, got.we, got.wd, exp.wa, exp.we, exp.wd);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; memOp_i = 4'd0; reg_waddr_i = 5'd0; reg_we_i = 1'b0; reg_wdata_i = 32'd0;
      store_data_i = 32'd0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'd0;
      repeat (2) @(negedge clk_i);
      checks++;
      if ({dbus_req_o, reg_we_o, misalign_o, stall_req_o, reg_waddr_o, reg_wdata_o, dbus_addr_o,
           dbus_be_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b we=%b mis=%b stall=%b wa=%0d wd=%h addr=%h be=%b expected all 0",
                  dbus_req_o, reg_we_o, misalign_o, stall_req_o, reg_waddr_o, reg_wdata_o,
                  dbus_addr_o, dbus_be_o);
      end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_passthrough();
      run_op(4'd0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 0, 32'd0, 4'd0, 32'd0, 32'd0);
      run_op(4'd12, 32'hFFFF_0001, 32'd0, 5'd31, 1'b1, 0, 32'd0, 4'd0, 32'd0, 32'd0);
      run_op(4'd0, 32'h8000_0000, 32'd0, 5'd9, 1'b0, 0, 32'd0, 4'd0, 32'd0, 32'd0);
   endtask

   task automatic test_loads();
      run_op(4'd1, 32'h0000_1003, 32'd0, 5'd3, 1'b1, 0, 32'h80FF_0000, 4'b1000, 32'd0,
             32'hFFFF_FF80);
      run_op(4'd5, 32'h0000_0000, 32'd0, 5'd4, 1'b1, 1, 32'h0000_8001, 4'b0011, 32'd0,
             32'h0000_8001);
      run_op(4'd2, 32'h0000_0002, 32'd0, 5'd6, 1'b1, 0, 32'h8001_0000, 4'b1100, 32'd0,
             32'hFFFF_8001);
      run_op(4'd4, 32'h0000_5002, 32'd0, 5'd7, 1'b1, 2, 32'h11AA_2233, 4'b0100, 32'd0,
             32'h0000_00AA);
      run_op(4'd3, 32'h0000_6000, 32'd0, 5'd8, 1'b1, 0, 32'h89AB_CDEF, 4'b1111, 32'd0,
             32'h89AB_CDEF);
   endtask

   task automatic test_stores();
      run_op(4'd7, 32'h0000_2002, 32'hDEAD_BEEF, 5'd10, 1'b1, 3, 32'd0, 4'b1100, 32'hBEEF_BEEF,
             32'd0);
      run_op(4'd6, 32'h0000_3001, 32'h1234_5678, 5'd11, 1'b1, 1, 32'd0, 4'b0010, 32'h7878_7878,
             32'd0);
      run_op(4'd8, 32'h0000_4000, 32'hCAFE_F00D, 5'd12, 1'b1, 2, 32'd0, 4'b1111, 32'hCAFE_F00D,
             32'd0);
   endtask

   task automatic test_back_to_back();
      run_op(4'd0, 32'h0000_0011, 32'd0, 5'd1, 1'b1, 0, 32'd0, 4'd0, 32'd0, 32'd0);
      run_op(4'd3, 32'h0000_0100, 32'd0, 5'd2, 1'b1, 0, 32'h0BAD_F00D, 4'b1111, 32'd0,
             32'h0BAD_F00D);
      run_op(4'd0, 32'h0000_0022, 32'd0, 5'd3, 1'b1, 0, 32'd0, 4'd0, 32'd0, 32'd0);
      run_op(4'd6, 32'h0000_0200, 32'h0000_00C3, 5'd4, 1'b1, 0, 32'd0, 4'b0001, 32'hC3C3_C3C3,
             32'd0);
      run_op(4'd0, 32'h0000_0033, 32'd0, 5'd5, 1'b0, 0, 32'd0, 4'd0, 32'd0, 32'd0);
   endtask

   task automatic test_random_loads();
      for (int n = 0; n < 12; n++) begin
         logic [3:0]  op;
         logic [31:0] addr, rdata;
         logic [3:0]  be;
         op    = 4'($urandom_range(1, 5));
         addr  = $urandom;
         rdata = $urandom;
         if (op == 4'd2 || op == 4'd5) begin
            addr[0] = 1'b0;
            be = 4'b0011 << (2 * addr[1]);
         end else if (op == 4'd3) begin
            addr[1:0] = 2'b00;
            be = 4'b1111;
         end else begin
            be = 4'b0001 << addr[1:0];
         end
         run_op(op, addr, 32'd0, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), rdata, be, 32'd0, exp_load(op, addr, rdata));
      end
   endtask

   task automatic test_reset_busy();
      memOp_i = 4'd3; reg_wdata_i = 32'h0000_0040; reg_waddr_i = 5'd9; reg_we_i = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if (dbus_req_o !== 1'b1) begin
         errors++; $display("FAIL busy_req: got %b expected 1", dbus_req_o);
      end
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if ({dbus_req_o, reg_we_o, misalign_o, dbus_addr_o, dbus_be_o, reg_wdata_o} !== '0) begin
         errors++;
         $display("FAIL async_reset: got req=%b we=%b mis=%b addr=%h be=%b wd=%h expected all 0",
                  dbus_req_o, reg_we_o, misalign_o, dbus_addr_o, dbus_be_o, reg_wdata_o);
      end
      memOp_i = 4'd0;
      @(negedge clk_i);
      rst_i = 1'b0;
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
      reg_waddr_i = 5'd7; reg_we_i = 1'b1; reg_wdata_i = 32'h0000_0055;
      #1;
      checks++;
      if (stall_req_o !== 1'b0) begin
         errors++; $display("FAIL idle_ack_stall: got %b expected 0", stall_req_o);
      end
      @(posedge clk_i); #1;
      dbus_ack_i = 1'b0;
      checks++;
      if ({dbus_req_o, reg_waddr_o, reg_we_o, reg_wdata_o} !== {1'b0, 5'd7, 1'b1, 32'h55}) begin
         errors++;
         $display("FAIL idle_ack_pass: got req=%b wa=%0d we=%b wd=%h expected 0 7 1 00000055",
                  dbus_req_o, reg_waddr_o, reg_we_o, reg_wdata_o);
      end
   endtask

   task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
      memOp_i = 4'd3; reg_wdata_i = 32'h0000_1001; reg_waddr_i = 5'd13; reg_we_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (stall_req_o !== 1'b0) begin
         errors++; $display("FAIL mis_stall: got %b expected 0", stall_req_o);
      end
      @(posedge clk_i); #1;
      memOp_i = 4'd0;
      checks++;
      if ({dbus_req_o, misalign_o, reg_we_o, reg_wdata_o} !== {1'b0, 1'b1, 1'b0, 32'h1001}) begin
         errors++;
         $display("FAIL mis_trap: got req=%b mis=%b we=%b wd=%h expected 0 1 0 00001001",
                  dbus_req_o, misalign_o, reg_we_o, reg_wdata_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (misalign_o !== 1'b0) begin
         errors++; $display("FAIL mis_pulse: got %b expected 0", misalign_o);
      end
`else
      run_op(4'd3, 32'h0000_1001, 32'd0, 5'd13, 1'b1, 0, 32'h1357_9BDF, 4'b1111, 32'd0,
             32'h1357_9BDF);
      checks++;
      if (misalign_o !== 1'b0) begin
         errors++; $display("FAIL mis_tied: got %b expected 0", misalign_o);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_loads();
      test_stores();
      test_back_to_back();
      test_random_loads();
      test_reset_busy();
      test_misalign();
      memOp_i = 4'd0;
      repeat (2) @(posedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
